// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: arbiter state encodings, port indices and default deselect gap
package spi_arb_pkg;
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_OWN0 = 2'd1;
  localparam logic [1:0] ARB_OWN1 = 2'd2;
  localparam logic [1:0] ARB_GAP = 2'd3;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
  localparam int DESELECT_DEFAULT = 4;
endpackage

// File: rtl/spi_flash_bus_arbiter.sv
// spi_flash_bus_arbiter: per-transaction sharing of one SPI flash bus between two masters with a deselect gap
module spi_flash_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int DESELECT_CYCLES = DESELECT_DEFAULT,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  output logic gnt0,
  input  logic cs_b0,
  input  logic sck0,
  input  logic mosi0,
  output logic miso0,
  input  logic req1,
  output logic gnt1,
  input  logic cs_b1,
  input  logic sck1,
  input  logic mosi1,
  output logic miso1,
  output logic spi_cs_b,
  output logic spi_sck,
  output logic spi_mosi,
  input  logic spi_miso
);
  localparam int CW = DESELECT_CYCLES > 0 ? $clog2(DESELECT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] GAP_LOAD = CW'(DESELECT_CYCLES > 0 ? DESELECT_CYCLES - 1 : 0);
  logic [1:0] state, state_nxt;
  logic last_owner;
  logic [CW-1:0] gap_cnt;
  logic pick1;
  // on a tie round-robin hands the bus to whoever did not own it last
  always_comb begin
    pick1 = (req0 && req1) ? (ROUND_ROBIN && last_owner == PORT0) : req1;
    state_nxt = state;
    case (state)
      ARB_IDLE: state_nxt = (req0 || req1) ? (pick1 ? ARB_OWN1 : ARB_OWN0) : ARB_IDLE;
      ARB_OWN0: state_nxt = req0 ? ARB_OWN0 : (DESELECT_CYCLES > 0 ? ARB_GAP : ARB_IDLE);
      ARB_OWN1: state_nxt = req1 ? ARB_OWN1 : (DESELECT_CYCLES > 0 ? ARB_GAP : ARB_IDLE);
      default:  state_nxt = gap_cnt == '0 ? ARB_IDLE : ARB_GAP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      last_owner <= PORT1;
      gap_cnt <= '0;
    end else begin
      state <= state_nxt;
      gnt0 <= state_nxt == ARB_OWN0;
      gnt1 <= state_nxt == ARB_OWN1;
      if (state_nxt == ARB_OWN0) last_owner <= PORT0;
      if (state_nxt == ARB_OWN1) last_owner <= PORT1;
      gap_cnt <= (state != ARB_GAP && state_nxt == ARB_GAP) ? GAP_LOAD :
                 (state == ARB_GAP && gap_cnt != '0) ? gap_cnt - CW'(1) : '0;
    end
  end
  // pins follow the registered grants only, so dropping req forces cs_b high on the grant-fall edge
  assign spi_cs_b = gnt0 ? cs_b0 : gnt1 ? cs_b1 : 1'b1;
  assign spi_sck = gnt0 ? sck0 : gnt1 ? sck1 : 1'b1;
  assign spi_mosi = gnt0 ? mosi0 : gnt1 ? mosi1 : 1'b0;
  assign miso0 = gnt0 ? spi_miso : 1'b1;
  assign miso1 = gnt1 ? spi_miso : 1'b1;
  assert property (@(posedge clk) disable iff (reset) !(gnt0 && gnt1));
endmodule

// File: tb/tb_spi_flash_bus_arbiter.sv
// tb_spi_flash_bus_arbiter: randomized scoreboard bench against a timestamp-based arbitration model
module tb_spi_flash_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic cs_b0 = 1'b1, sck0 = 1'b1, mosi0 = 1'b0;
  logic cs_b1 = 1'b1, sck1 = 1'b1, mosi1 = 1'b0;
  logic spi_miso = 1'b1;
  logic [1:0] gnt0, gnt1, miso0, miso1, spi_cs_b, spi_sck, spi_mosi;
  int owner[2] = '{-1, -1};
  int avail[2] = '{0, 0};
  bit last[2] = '{1'b1, 1'b1};
  int cyc = 0;
  int vectors = 0, miscompares = 0;
  logic [13:0] q[$];
  always #5 clk = ~clk;
  spi_flash_bus_arbiter #(.DESELECT_CYCLES(4), .ROUND_ROBIN(1'b1)) dut_a (
    .clk(clk), .reset(reset),
    .req0(req0), .gnt0(gnt0[0]), .cs_b0(cs_b0), .sck0(sck0), .mosi0(mosi0), .miso0(miso0[0]),
    .req1(req1), .gnt1(gnt1[0]), .cs_b1(cs_b1), .sck1(sck1), .mosi1(mosi1), .miso1(miso1[0]),
    .spi_cs_b(spi_cs_b[0]), .spi_sck(spi_sck[0]), .spi_mosi(spi_mosi[0]), .spi_miso(spi_miso)
  );
  spi_flash_bus_arbiter #(.DESELECT_CYCLES(0), .ROUND_ROBIN(1'b0)) dut_b (
    .clk(clk), .reset(reset),
    .req0(req0), .gnt0(gnt0[1]), .cs_b0(cs_b0), .sck0(sck0), .mosi0(mosi0), .miso0(miso0[1]),
    .req1(req1), .gnt1(gnt1[1]), .cs_b1(cs_b1), .sck1(sck1), .mosi1(mosi1), .miso1(miso1[1]),
    .spi_cs_b(spi_cs_b[1]), .spi_sck(spi_sck[1]), .spi_mosi(spi_mosi[1]), .spi_miso(spi_miso)
  );
  // model: an owner keeps the bus until its req drops; the bus may be re-granted no earlier than edge release+d+1
  task automatic step(input int i, input int d, input bit rr);
    if (reset) begin
      owner[i] = -1;
      last[i] = 1'b1;
      avail[i] = cyc + 1;
    end else if (owner[i] >= 0) begin
      if (!(owner[i] == 0 ? req0 : req1)) begin
        owner[i] = -1;
        avail[i] = cyc + d + 1;
      end
    end else if (cyc >= avail[i] && (req0 || req1)) begin
      owner[i] = (req0 && req1) ? (rr ? int'(!last[i]) : 0) : (req1 ? 1 : 0);
      last[i] = owner[i] == 1;
    end
  endtask
  function automatic logic [6:0] expect_out(input int o);
    return o == 0 ? {2'b10, cs_b0, sck0, mosi0, spi_miso, 1'b1} :
           o == 1 ? {2'b01, cs_b1, sck1, mosi1, 1'b1, spi_miso} : 7'b0011011;
  endfunction
  initial begin
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = (c < 3) || ($urandom_range(0, 199) == 0);
      req0 = req0 ? ($urandom_range(0, 15) != 0 && !(owner[0] == 0 && $urandom_range(0, 7) == 0))
                  : ($urandom_range(0, 3) == 0);
      req1 = req1 ? ($urandom_range(0, 15) != 0 && !(owner[0] == 1 && $urandom_range(0, 7) == 0))
                  : ($urandom_range(0, 3) == 0);
      {cs_b0, sck0, mosi0, cs_b1, sck1, mosi1, spi_miso} = 7'($urandom);
      step(0, 4, 1'b1);
      step(1, 0, 1'b0);
      q.push_back({expect_out(owner[0]), expect_out(owner[1])});
      cyc++;
    end
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: %0d entries left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    logic [13:0] act, expv;
    int since[2] = '{-1, -1};
    bit had[2] = '{1'b0, 1'b0};
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        expv = q.pop_front();
        act = {gnt0[0], gnt1[0], spi_cs_b[0], spi_sck[0], spi_mosi[0], miso0[0], miso1[0],
               gnt0[1], gnt1[1], spi_cs_b[1], spi_sck[1], spi_mosi[1], miso0[1], miso1[1]};
        vectors++;
        if (act !== expv) begin
          miscompares++;
          $display("FAIL outputs t=%0t got %b required %b", $time, act, expv);
        end
      end
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (gnt0[i] === 1'b1 && gnt1[i] === 1'b1) begin
          miscompares++;
          $display("FAIL exclusive inst%0d t=%0t got gnt0=gnt1=1 required not both", i, $time);
        end
        if (reset) since[i] = -1;
        else if ((gnt0[i] || gnt1[i]) && !had[i] && since[i] >= 0) begin
          vectors++;
          if (since[i] < (i == 0 ? 5 : 1)) begin
            miscompares++;
            $display("FAIL gap inst%0d t=%0t got %0d idle cycles required >= %0d", i, $time,
                     since[i], i == 0 ? 5 : 1);
          end
        end else if (!(gnt0[i] || gnt1[i]) && had[i]) since[i] = 1;
        else if (!(gnt0[i] || gnt1[i]) && since[i] >= 0) since[i]++;
        had[i] = gnt0[i] || gnt1[i];
      end
    end
  end
endmodule
